cache_fill_responder: RTL and testbench

//   Memory-side responder for the two-way cache's line-fill request port. Accepts a cacheline

---
 rtl/cache_fill_pkg.sv | 20 ++
 rtl/fill_line_buffer.sv | 50 +++++
 rtl/cache_fill_responder.sv | 218 +++++++++++++++++++++
 tb/tb_cache_fill_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the cache line-fill responder.
// Build option: FILL_WRITE_EN adds the single-word write path (WRITE/WDONE states).
package cache_fill_pkg;

    localparam int BURST_LEN = 4;
    localparam int IDX_W     = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        MEMREQ,
        COLLECT,
        STREAM
`ifdef FILL_WRITE_EN
        ,
        WRITE,
        WDONE
`endif
    } state_t;

endpackage

// File: rtl/fill_line_buffer.sv
// One-cacheline register file. Words land in linear order from the line base;
// the read port adds a rotation offset to a base index so the line can be
// replayed critical-word-first. A write to the word being read in the same
// cycle is forwarded, which lets the stream start on the cycle right after the
// last word arrives even when that last word is the critical one.
module fill_line_buffer #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    localparam int IDX_W    = $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_base,
    input  logic [IDX_W-1:0]  rd_offset,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] line_mem [BURST_LEN];
    logic [DATA_W-1:0] rd_data_reg;
    logic [IDX_W-1:0]  rd_idx;

    // Index arithmetic wraps naturally modulo the line length.
    assign rd_idx  = rd_base + rd_offset;
    assign rd_data = rd_data_reg;

    // Capture incoming memory words; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_idx] <= wr_data;
        end
    end

    // Registered rotated read with write-through forwarding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_idx == rd_idx)) begin
                rd_data_reg <= wr_data;
            end else begin
                rd_data_reg <= line_mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/cache_fill_responder.sv
// Memory-side responder for the cache line-fill port: fetches one burst from
// the SDRAM native port and returns it critical-word-first as an unbroken
// stream with a single-cycle cache_fill marker on the first word.
// Build option: FILL_WRITE_EN enables single-word writes (cache_rw=0);
// without it write requests are ignored and cache_wr_ack/mem_we are tied low.
module cache_fill_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_req,
    input  logic              cache_rw,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [DATA_W-1:0] cache_wdata,
    input  logic [1:0]        cache_ben,
    output logic [DATA_W-1:0] cache_data,
    output logic              cache_fill,
    output logic              cache_wr_ack,
    output logic              busy,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_ben,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    import cache_fill_pkg::*;

    localparam int             CNT_W    = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  crit_reg, crit_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  k_reg, k_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              cache_fill_reg, cache_fill_next;
    logic              busy_reg, busy_next;
    logic              buf_we;
    logic              buf_rd_en;
    logic [CNT_W-1:0]  buf_rd_offset;

`ifdef FILL_WRITE_EN
    logic              mem_we_reg, mem_we_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [1:0]        mem_ben_reg, mem_ben_next;
    logic              wr_ack_reg, wr_ack_next;
`endif

    fill_line_buffer #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (buf_we),
        .wr_idx    (cnt_reg),
        .wr_data   (mem_rdata),
        .rd_en     (buf_rd_en),
        .rd_base   (crit_reg),
        .rd_offset (buf_rd_offset),
        .rd_data   (cache_data)
    );

    // Next-state and registered-output decode; every output is a register.
    always_comb begin
        state_next      = state_reg;
        crit_next       = crit_reg;
        cnt_next        = cnt_reg;
        k_next          = k_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        cache_fill_next = 1'b0;
        buf_we          = 1'b0;
        buf_rd_en       = 1'b0;
        buf_rd_offset   = '0;
`ifdef FILL_WRITE_EN
        mem_we_next     = mem_we_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_ben_next    = mem_ben_reg;
        wr_ack_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (cache_req && cache_rw) begin
                    crit_next     = cache_addr[CNT_W:1];
                    cnt_next      = '0;
                    k_next        = '0;
                    mem_addr_next = {cache_addr[ADDR_W-1:CNT_W+1], {(CNT_W+1){1'b0}}};
                    mem_req_next  = 1'b1;
`ifdef FILL_WRITE_EN
                    mem_we_next   = 1'b0;
`endif
                    state_next    = MEMREQ;
                end
`ifdef FILL_WRITE_EN
                else if (cache_req) begin
                    mem_addr_next  = cache_addr;
                    mem_wdata_next = cache_wdata;
                    mem_ben_next   = cache_ben;
                    mem_we_next    = 1'b1;
                    mem_req_next   = 1'b1;
                    state_next     = WRITE;
                end
`endif
            end
            MEMREQ, COLLECT: begin
                // Words may already stream in during the acknowledge cycle.
                if (mem_rvalid) begin
                    buf_we   = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (mem_rvalid && (cnt_reg == LAST_IDX)) begin
                    mem_req_next    = 1'b0;
                    buf_rd_en       = 1'b1;
                    buf_rd_offset   = '0;
                    cache_fill_next = 1'b1;
                    k_next          = '0;
                    state_next      = STREAM;
                end else if ((state_reg == MEMREQ) && mem_ack) begin
                    mem_req_next = 1'b0;
                    state_next   = COLLECT;
                end
            end
            STREAM: begin
                // k_reg is the word currently on cache_data; fetch the next one.
                if (k_reg == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    buf_rd_en     = 1'b1;
                    buf_rd_offset = k_reg + CNT_W'(1);
                    k_next        = k_reg + CNT_W'(1);
                end
            end
`ifdef FILL_WRITE_EN
            WRITE: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    wr_ack_next  = 1'b1;
                    state_next   = WDONE;
                end
            end
            WDONE: begin
                if (!cache_req) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            crit_reg       <= '0;
            cnt_reg        <= '0;
            k_reg          <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            cache_fill_reg <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef FILL_WRITE_EN
            mem_we_reg     <= 1'b0;
            mem_wdata_reg  <= '0;
            mem_ben_reg    <= '0;
            wr_ack_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            crit_reg       <= crit_next;
            cnt_reg        <= cnt_next;
            k_reg          <= k_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            cache_fill_reg <= cache_fill_next;
            busy_reg       <= busy_next;
`ifdef FILL_WRITE_EN
            mem_we_reg     <= mem_we_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_ben_reg    <= mem_ben_next;
            wr_ack_reg     <= wr_ack_next;
`endif
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign cache_fill = cache_fill_reg;
    assign busy       = busy_reg;

`ifdef FILL_WRITE_EN
    assign mem_we       = mem_we_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_ben      = mem_ben_reg;
    assign cache_wr_ack = wr_ack_reg;
`else
    // Read-only build: the write side is inert.
    logic unused_write_bits;
    assign unused_write_bits = ^{cache_wdata, cache_ben, cache_addr[0]};
    assign mem_we       = 1'b0;
    assign mem_wdata    = '0;
    assign mem_ben      = '0;
    assign cache_wr_ack = 1'b0;
`endif

endmodule

// File: tb/tb_cache_fill_responder.sv
// Self-checking bench for cache_fill_responder. A small memory model returns
// bursts with programmable gaps; the expected stream is computed directly as
// line[(crit + k) mod 4]. Honours FILL_WRITE_EN the same way as the design.
`timescale 1ns/1ps
module tb_cache_fill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_req, cache_rw;
    logic [31:0] cache_addr;
    logic [15:0] cache_wdata;
    logic [1:0]  cache_ben;
    logic [15:0] cache_data;
    logic        cache_fill, cache_wr_ack, busy;
    logic        mem_req, mem_ack, mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_ben;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl_words [4];
    int          mdl_gaps  [4];

    cache_fill_responder dut (
        .clk(clk), .reset(reset),
        .cache_req(cache_req), .cache_rw(cache_rw), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_ben(cache_ben),
        .cache_data(cache_data), .cache_fill(cache_fill),
        .cache_wr_ack(cache_wr_ack), .busy(busy),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One full line read as the cache and the memory would see it. Called at a negedge.
    task automatic do_read(input logic [31:0] addr, input int ack_dly, input bit rv_with_ack, input string tag);
        int          crit;
        int          n;
        int          w;
        logic        exp_fill;
        logic [15:0] exp_w [4];
        logic [31:0] exp_addr;
        crit = int'(addr[2:1]);
        for (int k = 0; k < 4; k++) exp_w[k] = mdl_words[(crit + k) % 4];
        exp_addr    = addr & 32'hFFFF_FFF8;
        cache_addr  = addr;
        cache_rw    = 1'b1;
        cache_wdata = 16'($urandom);
        cache_ben   = 2'($urandom);
        cache_req   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 20);
        checks++;
        if (n != 1) begin errors++; $display("FAIL %s req_latency: got %0d cycles, expected 1", tag, n); end
        if (mem_req !== 1'b1) begin cache_req = 1'b0; return; end
        checks++;
        if (mem_addr !== exp_addr) begin errors++; $display("FAIL %s mem_addr: got %h, expected %h", tag, mem_addr, exp_addr); end
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL %s mem_we: got %b, expected 0", tag, mem_we); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_req: got %b, expected 1", tag, busy); end
        repeat (ack_dly) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1) begin errors++; $display("FAIL %s mem_req_hold: got %b, expected 1", tag, mem_req); end
        end
        mem_ack = 1'b1;
        w = 0;
        if (rv_with_ack) begin mem_rvalid = 1'b1; mem_rdata = mdl_words[0]; w = 1; end
        @(negedge clk);
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req_drop: got %b, expected 0", tag, mem_req); end
        while (w < 4) begin
            repeat (mdl_gaps[w]) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = mdl_words[w];
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (w < 3) begin
                checks++;
                if (cache_fill !== 1'b0) begin errors++; $display("FAIL %s early_fill: got %b after word %0d, expected 0", tag, cache_fill, w); end
            end
            w++;
        end
        for (int k = 0; k < 4; k++) begin
            exp_fill = (k == 0);
            checks++;
            if (cache_fill !== exp_fill) begin errors++; $display("FAIL %s fill_k%0d: got %b, expected %b", tag, k, cache_fill, exp_fill); end
            checks++;
            if (cache_data !== exp_w[k]) begin errors++; $display("FAIL %s data_k%0d: got %h, expected %h", tag, k, cache_data, exp_w[k]); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_k%0d: got %b, expected 1", tag, k, busy); end
            if (k == 0) cache_req = 1'b0;
            mem_rvalid = 1'($urandom);
            mem_rdata  = 16'($urandom);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b, expected 0", tag, busy); end
        checks++;
        if (cache_fill !== 1'b0) begin errors++; $display("FAIL %s fill_end: got %b, expected 0", tag, cache_fill); end
        $display("read %s addr=%h crit=%0d stream=%h %h %h %h", tag, addr, crit, exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
    endtask

    task automatic test_reset();
        reset = 1'b0; cache_req = 1'b0; cache_rw = 1'b0; cache_addr = '0; cache_wdata = '0;
        cache_ben = '0; mem_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cache_fill !== 1'b0)   begin errors++; $display("FAIL reset cache_fill: got %b, expected 0", cache_fill); end
        checks++; if (cache_wr_ack !== 1'b0) begin errors++; $display("FAIL reset cache_wr_ack: got %b, expected 0", cache_wr_ack); end
        checks++; if (mem_req !== 1'b0)      begin errors++; $display("FAIL reset mem_req: got %b, expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL reset mem_we: got %b, expected 0", mem_we); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
        checks++; if (cache_data !== 16'h0)  begin errors++; $display("FAIL reset cache_data: got %h, expected 0", cache_data); end
        checks++; if (mem_addr !== 32'h0)    begin errors++; $display("FAIL reset mem_addr: got %h, expected 0", mem_addr); end
        checks++; if (mem_wdata !== 16'h0)   begin errors++; $display("FAIL reset mem_wdata: got %h, expected 0", mem_wdata); end
        checks++; if (mem_ben !== 2'b00)     begin errors++; $display("FAIL reset mem_ben: got %b, expected 0", mem_ben); end
        reset = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_read_gapless();
        for (int i = 0; i < 4; i++) begin mdl_words[i] = 16'h00A0 + 16'(i); mdl_gaps[i] = 0; end
        do_read(32'h0000_1234, 0, 1'b0, "gapless");
    endtask

    task automatic test_read_gaps();
        mdl_gaps[0] = 0; mdl_gaps[1] = 3; mdl_gaps[2] = 1; mdl_gaps[3] = 5;
        do_read(32'h0000_1234, 1, 1'b0, "gaps");
    endtask

    task automatic test_crit_orders();
        for (int i = 0; i < 4; i++) begin mdl_words[i] = 16'($urandom); mdl_gaps[i] = 0; end
        do_read(32'h0000_2000, 0, 1'b0, "crit0");
        for (int i = 0; i < 4; i++) mdl_words[i] = 16'($urandom);
        do_read(32'h0000_2006, 2, 1'b1, "crit3");
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 4; i++) mdl_words[i] = 16'($urandom);
        cache_addr = 32'h0000_0044; cache_rw = 1'b1; cache_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 20);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL midreset req: got %b, expected 1", mem_req); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1; mem_rdata = mdl_words[i];
            @(negedge clk);
        end
        mem_rvalid = 1'b0; reset = 1'b0; cache_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL midreset busy: got %b, expected 0", busy); end
        checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL midreset mem_req: got %b, expected 0", mem_req); end
        checks++; if (cache_data !== 16'h0) begin errors++; $display("FAIL midreset cache_data: got %h, expected 0", cache_data); end
        for (int c = 0; c < 8; c++) begin
            mem_rvalid = (c < 2); mem_rdata = 16'($urandom);
            @(negedge clk);
            checks++;
            if (cache_fill !== 1'b0) begin errors++; $display("FAIL midreset stray_fill: got %b at cycle %0d, expected 0", cache_fill, c); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL midreset stray_busy: got %b at cycle %0d, expected 0", busy, c); end
        end
        mem_rvalid = 1'b0;
        $display("reset during collect: transaction abandoned");
        for (int i = 0; i < 4; i++) begin mdl_words[i] = 16'($urandom); mdl_gaps[i] = 0; end
        do_read(32'h0000_5552, 0, 1'b0, "after_reset");
    endtask

    task automatic test_write();
        int acks;
        cache_addr = 32'h0000_0100; cache_wdata = 16'hBEEF; cache_ben = 2'b01;
        cache_rw = 1'b0; cache_req = 1'b1;
        @(negedge clk);
`ifdef FILL_WRITE_EN
        checks++; if (mem_req !== 1'b1)          begin errors++; $display("FAIL write mem_req: got %b, expected 1", mem_req); end
        checks++; if (mem_we !== 1'b1)           begin errors++; $display("FAIL write mem_we: got %b, expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h100)      begin errors++; $display("FAIL write mem_addr: got %h, expected 100", mem_addr); end
        checks++; if (mem_wdata !== 16'hBEEF)    begin errors++; $display("FAIL write mem_wdata: got %h, expected beef", mem_wdata); end
        checks++; if (mem_ben !== 2'b01)         begin errors++; $display("FAIL write mem_ben: got %b, expected 01", mem_ben); end
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (cache_wr_ack !== 1'b1) begin errors++; $display("FAIL write ack_pulse: got %b, expected 1", cache_wr_ack); end
        checks++; if (mem_req !== 1'b0)      begin errors++; $display("FAIL write mem_req_drop: got %b, expected 0", mem_req); end
        cache_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cache_wr_ack === 1'b1) acks++;
        end
        checks++; if (acks != 0)     begin errors++; $display("FAIL write extra_acks: got %0d, expected 0", acks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write busy_end: got %b, expected 0", busy); end
`else
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL write_off mem_req: got %b at cycle %0d, expected 0", mem_req, c); end
            if (cache_wr_ack === 1'b1) acks++;
            @(negedge clk);
        end
        checks++; if (acks != 0)     begin errors++; $display("FAIL write_off acks: got %0d, expected 0", acks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_off busy: got %b, expected 0", busy); end
        cache_req = 1'b0;
`endif
        cache_rw = 1'b1;
        $display("write addr=00000100 data=beef ben=01 done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin mdl_words[i] = 16'($urandom); mdl_gaps[i] = 0; end
        do_read(32'h0000_3002, 0, 1'b0, "b2b_first");
        for (int i = 0; i < 4; i++) mdl_words[i] = 16'($urandom);
        do_read(32'h0000_3804, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) begin
                mdl_words[i] = 16'($urandom);
                mdl_gaps[i]  = $urandom_range(0, 3);
            end
            do_read($urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL random idle_busy: got %b, expected 0", busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_gapless();
        test_read_gaps();
        test_crit_orders();
        test_reset_mid();
        test_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
